out_pulse_stretch: RTL and testbench

- Output-side counterpart to the input synchronizer.
- Takes single-cycle event strobes generated in the `clk` domain and drives a registered, glitch-free external pulse. Each pulse has a guaranteed minimum high width and minimum low gap, so a slow or asynchronous observer (LED, another board's synchronizer) cannot miss an event.
- Events that arrive while a pulse is in progress are queued in a saturating counter.

---
 rtl/out_pulse_pkg.sv | 21 ++
 rtl/out_pulse_stretch_if.sv | 31 +++
 rtl/cycle_timer.sv | 26 ++
 rtl/out_pulse_stretch.sv | 147 ++++++++++++++
 tb/tb_out_pulse_stretch.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/out_pulse_pkg.sv
// Shared types and defaults for the out_pulse_stretch output pulse stretcher.
package out_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int HIGH_CYCLES_DEF = 4;
  localparam int GAP_CYCLES_DEF  = 4;
  localparam int PEND_W_DEF      = 3;

  // Bits needed to hold max(high, gap) - 1, never less than one.
  function automatic int timer_width(input int high_cycles, input int gap_cycles);
    int m;
    m = (high_cycles > gap_cycles) ? high_cycles : gap_cycles;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/out_pulse_stretch_if.sv
// Event/status bundle between an event source and out_pulse_stretch.
interface out_pulse_stretch_if
  import out_pulse_pkg::*;
#(
  parameter int PEND_W = PEND_W_DEF
);
  logic              event_in;
  logic              clr_ovf;
  logic              out_pulse;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    output event_in,
    output clr_ovf,
    input  out_pulse,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  event_in,
    input  clr_ovf,
    output out_pulse,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/cycle_timer.sv
// Loadable down-counter that stops at zero; load takes priority over counting.
module cycle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/out_pulse_stretch.sv
// Stretches single-cycle event strobes into spaced external pulses, queueing
// events that arrive mid-pulse. Define PULSE_TOGGLE_EN for toggle-style output.
//
// state | meaning
// IDLE  | no pulse in progress, output at rest
// HIGH  | pulse high phase, HIGH_CYCLES long
// GAP   | enforced low gap, GAP_CYCLES long
module out_pulse_stretch
  import out_pulse_pkg::*;
#(
  parameter int HIGH_CYCLES = HIGH_CYCLES_DEF,
  parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
  parameter int PEND_W      = PEND_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  out_pulse_stretch_if.slave bus
);

  localparam int TW = timer_width(HIGH_CYCLES, GAP_CYCLES);
  localparam logic [TW-1:0]     HIGH_LD  = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0]     GAP_LD   = TW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_HIGH = HIGH;
  localparam logic [1:0] S_GAP  = GAP;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              tmr_load;
  logic [TW-1:0]     tmr_ld_val;
  logic              tmr_zero;
  logic [PEND_W-1:0] pending_q;
  logic              overflow_q;
  logic              out_pulse_q;
  logic              pend_nz;
  logic              pend_full;
  logic              gap_done;
  logic              start_high;
  logic              inc;
  logic              dec;
  logic              drop;

  assign pend_nz   = (pending_q != '0);
  assign pend_full = (pending_q == PEND_MAX);
  assign gap_done  = (state == S_GAP) && tmr_zero;

  // A queued event left over in IDLE (strobe on the final gap edge) launches
  // a pulse on its own, so nothing is ever stranded in the counter.
  assign start_high = ((state == S_IDLE) && (bus.event_in || pend_nz)) ||
                      (gap_done && pend_nz);
  assign dec  = pend_nz && (gap_done || (state == S_IDLE));
  assign inc  = bus.event_in && ((state != S_IDLE) || pend_nz);
  assign drop = inc && !dec && pend_full;

  always_comb begin
    state_nxt  = state;
    tmr_load   = 1'b0;
    tmr_ld_val = HIGH_LD;
    case (state)
      S_IDLE: begin
        if (start_high) begin
          state_nxt = S_HIGH;
          tmr_load  = 1'b1;
        end
      end
      S_HIGH: begin
        if (tmr_zero) begin
          state_nxt  = S_GAP;
          tmr_load   = 1'b1;
          tmr_ld_val = GAP_LD;
        end
      end
      S_GAP: begin
        if (tmr_zero) begin
          if (pend_nz) begin
            state_nxt = S_HIGH;
            tmr_load  = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  cycle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_ld_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pulse_q <= 1'b0;
    end else begin
`ifdef PULSE_TOGGLE_EN
      if (start_high) begin
        out_pulse_q <= ~out_pulse_q;
      end
`else
      out_pulse_q <= (state_nxt == S_HIGH);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      case ({inc, dec})
        2'b10: if (!pend_full) pending_q <= pending_q + 1'b1;
        2'b01: pending_q <= pending_q - 1'b1;
        default: pending_q <= pending_q;
      endcase
    end
  end

  // A drop on the same edge as clr_ovf keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_q <= 1'b0;
    end
  end

  assign bus.out_pulse = out_pulse_q;
  assign bus.busy      = (state != S_IDLE);
  assign bus.pending   = pending_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_out_pulse_stretch.sv
// Scoreboard bench for out_pulse_stretch; expectations are queued per period.
module tb_out_pulse_stretch;

  localparam int SIG_PULSE = 0;
  localparam int SIG_BUSY  = 1;
  localparam int SIG_PEND  = 2;
  localparam int SIG_OVF   = 3;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string tag;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  int    cyc = 0;
  int    t0 = 0;
  int    n_chk = 0;
  int    n_fail = 0;
  string tname = "init";
  exp_t  sb[$];

  out_pulse_stretch_if #(.PEND_W(3)) bus ();

  out_pulse_stretch #(
    .HIGH_CYCLES (4),
    .GAP_CYCLES  (4),
    .PEND_W      (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int sample(input int sig);
    case (sig)
      SIG_PULSE: return int'(bus.out_pulse);
      SIG_BUSY:  return int'(bus.busy);
      SIG_PEND:  return int'(bus.pending);
      default:   return int'(bus.overflow);
    endcase
  endfunction

  function automatic void exp_at(input int rel, input int sig, input int val, input string what);
    exp_t e;
    int   i;
    e.cyc = t0 + rel;
    e.sig = sig;
    e.val = val;
    e.tag = $sformatf("%s.%s@%0d", tname, what, rel);
    i = 0;
    while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
    sb.insert(i, e);
  endfunction

  // Level-pulse expectations apply only to the default build.
  function automatic void exp_pulse(input int rel, input int val);
`ifndef PULSE_TOGGLE_EN
    exp_at(rel, SIG_PULSE, val, "pulse");
`endif
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) chk({e.tag, "_stale"}, cyc, e.cyc);
      else             chk(e.tag, sample(e.sig), e.val);
    end
  end

  task automatic begin_test(input string name);
    @(negedge clk);
    tname = name;
    t0 = cyc;
  endtask

  task automatic run_test(input int n, input logic [127:0] ev, input logic [127:0] cl);
    for (int r = 0; r < n; r++) begin
      bus.event_in = ev[r];
      bus.clr_ovf  = cl[r];
      @(negedge clk);
    end
    bus.event_in = 1'b0;
    bus.clr_ovf  = 1'b0;
    #1;
    chk({tname, ".sb_drain"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ev;
    logic [127:0] cl;
    bus.event_in = 1'b0;
    bus.clr_ovf  = 1'b0;
    #1;
    chk("rst.pulse", int'(bus.out_pulse), 0);
    chk("rst.busy", int'(bus.busy), 0);
    chk("rst.pending", int'(bus.pending), 0);
    chk("rst.overflow", int'(bus.overflow), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single event
    begin_test("single");
    ev = '0; cl = '0; ev[10] = 1'b1;
    exp_pulse(10, 0);
    for (int r = 11; r <= 14; r++) exp_pulse(r, 1);
    for (int r = 15; r <= 19; r++) exp_pulse(r, 0);
    exp_at(10, SIG_BUSY, 0, "busy");
    for (int r = 11; r <= 18; r++) exp_at(r, SIG_BUSY, 1, "busy");
    exp_at(19, SIG_BUSY, 0, "busy");
    exp_at(12, SIG_PEND, 0, "pend");
    run_test(22, ev, cl);

    // Burst of three
    begin_test("burst");
    ev = '0; cl = '0; ev[10] = 1'b1; ev[11] = 1'b1; ev[12] = 1'b1;
    exp_at(12, SIG_PEND, 1, "pend");
    exp_at(13, SIG_PEND, 2, "pend");
    exp_at(18, SIG_PEND, 2, "pend");
    exp_at(19, SIG_PEND, 1, "pend");
    exp_at(26, SIG_PEND, 1, "pend");
    exp_at(27, SIG_PEND, 0, "pend");
    exp_pulse(11, 1); exp_pulse(15, 0);
    exp_pulse(18, 0); exp_pulse(19, 1); exp_pulse(23, 0);
    exp_pulse(26, 0); exp_pulse(27, 1); exp_pulse(31, 0);
    exp_at(34, SIG_BUSY, 1, "busy");
    exp_at(35, SIG_BUSY, 0, "busy");
    exp_at(35, SIG_OVF, 0, "ovf");
    run_test(37, ev, cl);

    // Event on the final gap edge together with a pending decrement
    begin_test("simul");
    ev = '0; cl = '0; ev[10] = 1'b1; ev[12] = 1'b1; ev[18] = 1'b1;
    exp_at(13, SIG_PEND, 1, "pend");
    exp_at(18, SIG_PEND, 1, "pend");
    exp_at(19, SIG_PEND, 1, "pend");
    exp_pulse(18, 0); exp_pulse(19, 1);
    exp_at(20, SIG_OVF, 0, "ovf");
    exp_at(27, SIG_PEND, 0, "pend");
    exp_pulse(27, 1);
    exp_at(34, SIG_BUSY, 1, "busy");
    exp_at(35, SIG_BUSY, 0, "busy");
    run_test(37, ev, cl);

    // Saturation, drop with simultaneous clear, later clear, full drain
    begin_test("sat");
    ev = '0; cl = '0;
    for (int r = 10; r <= 19; r++) ev[r] = 1'b1;
    cl[19] = 1'b1; cl[22] = 1'b1;
    exp_at(18, SIG_PEND, 7, "pend");
    exp_at(19, SIG_PEND, 7, "pend");
    exp_at(19, SIG_OVF, 0, "ovf");
    exp_at(20, SIG_PEND, 7, "pend");
    exp_at(20, SIG_OVF, 1, "ovf");
    exp_at(22, SIG_OVF, 1, "ovf");
    exp_at(23, SIG_OVF, 0, "ovf");
    exp_at(26, SIG_PEND, 7, "pend");
    for (int k = 0; k <= 6; k++) exp_at(27 + 8 * k, SIG_PEND, 6 - k, "pend");
    for (int k = 0; k <= 7; k++) begin
      exp_pulse(19 + 8 * k, 1);
      exp_pulse(23 + 8 * k, 0);
    end
    exp_at(82, SIG_BUSY, 1, "busy");
    exp_at(83, SIG_BUSY, 0, "busy");
    run_test(86, ev, cl);

`ifdef PULSE_TOGGLE_EN
    begin_test("toggle");
    ev = '0; cl = '0; ev[10] = 1'b1; ev[12] = 1'b1;
    exp_at(10, SIG_PULSE, 0, "tog");
    exp_at(11, SIG_PULSE, 1, "tog");
    exp_at(15, SIG_PULSE, 1, "tog");
    exp_at(18, SIG_PULSE, 1, "tog");
    exp_at(19, SIG_PULSE, 0, "tog");
    exp_at(26, SIG_PULSE, 0, "tog");
    exp_at(27, SIG_BUSY, 0, "busy");
    exp_at(30, SIG_PULSE, 0, "tog");
    run_test(32, ev, cl);
`endif

    // Asynchronous reset in the middle of a pulse
    begin_test("areset");
    ev = '0; cl = '0; ev[10] = 1'b1; ev[11] = 1'b1;
    exp_at(12, SIG_PEND, 1, "pend");
    exp_at(12, SIG_BUSY, 1, "busy");
    run_test(12, ev, cl);
    #1 rst_n = 1'b0;
    #1;
    chk("areset.pulse", int'(bus.out_pulse), 0);
    chk("areset.busy", int'(bus.busy), 0);
    chk("areset.pending", int'(bus.pending), 0);
    chk("areset.overflow", int'(bus.overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin_test("post_rst");
    ev = '0; cl = '0; ev[2] = 1'b1;
    exp_at(1, SIG_BUSY, 0, "busy");
    exp_at(2, SIG_BUSY, 0, "busy");
    exp_at(2, SIG_PULSE, 0, "pulse");
    exp_at(3, SIG_BUSY, 1, "busy");
    exp_at(3, SIG_PEND, 0, "pend");
    exp_pulse(3, 1);
    exp_pulse(7, 0);
    exp_at(11, SIG_BUSY, 0, "busy");
    run_test(12, ev, cl);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
